// File: rtl/timer_counter_if.sv
// Bridge-side register bus of the timer: word select, write strobe/data and read data.
interface timer_counter_if;
  logic [1:0]  Addr;
  logic        WE;
  logic [31:0] DIn;
  logic [31:0] DOut;

  modport master (output Addr, output WE, output DIn, input DOut);
  modport slave  (input Addr, input WE, input DIn, output DOut);
endinterface

// File: rtl/timer_counter.sv
// Memory-mapped down-counting timer with one-shot and auto-reload periodic modes.
// IRQ feeds one CP0 HWInt bit; registers are CTRL, PRESET and read-only COUNT.
module timer_counter #(
  parameter int CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  timer_counter_if.slave        bus,
  output logic                  IRQ
);

  localparam logic [1:0] ADDR_CTRL   = 2'b00;
  localparam logic [1:0] ADDR_PRESET = 2'b01;
  localparam logic [1:0] ADDR_COUNT  = 2'b10;

  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_t;

  state_t             state_reg, state_next;
  logic [3:0]         ctrl_reg, ctrl_next;
  logic [CNT_W-1:0]   preset_reg, preset_next;
  logic [CNT_W-1:0]   count_reg, count_next;
  logic               irq_flag_reg, irq_flag_next;

  logic               enable;
  logic [1:0]         mode;
  logic               im;
  logic               wr_ctrl;
  logic               wr_preset;

  assign enable    = ctrl_reg[0];
  assign mode      = ctrl_reg[2:1];
  assign im        = ctrl_reg[3];
  assign wr_ctrl   = bus.WE && (bus.Addr == ADDR_CTRL);
  assign wr_preset = bus.WE && (bus.Addr == ADDR_PRESET);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg    <= IDLE;
      ctrl_reg     <= '0;
      preset_reg   <= '0;
      count_reg    <= '0;
      irq_flag_reg <= 1'b0;
    end else begin
      state_reg    <= state_next;
      ctrl_reg     <= ctrl_next;
      preset_reg   <= preset_next;
      count_reg    <= count_next;
      irq_flag_reg <= irq_flag_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    ctrl_next     = ctrl_reg;
    preset_next   = preset_reg;
    count_next    = count_reg;
    irq_flag_next = irq_flag_reg;

    case (state_reg)
      IDLE: begin
        if (enable) state_next = LOAD;
      end
      LOAD: begin
        count_next = preset_reg;
        state_next = CNT;
      end
      CNT: begin
        if (!enable) begin
          state_next = IDLE;
        end else if (count_reg <= CNT_W'(1)) begin
          count_next = '0;
          state_next = INT;
        end else begin
          count_next = count_reg - CNT_W'(1);
        end
      end
      INT: begin
        // Reserved modes 10/11 fall into the one-shot branch.
        if (mode == 2'b01) begin
          state_next = LOAD;
        end else begin
          ctrl_next[0]  = 1'b0;
          irq_flag_next = 1'b1;
          state_next    = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase

    // Bus writes override the FSM's Enable clear and flag set in the same cycle.
    if (wr_ctrl)   ctrl_next   = bus.DIn[3:0];
    if (wr_preset) preset_next = bus.DIn[CNT_W-1:0];
    if (wr_ctrl || wr_preset) irq_flag_next = 1'b0;
  end

  always_comb begin
    bus.DOut = '0;
    case (bus.Addr)
      ADDR_CTRL:   bus.DOut[3:0]       = ctrl_reg;
      ADDR_PRESET: bus.DOut[CNT_W-1:0] = preset_reg;
      ADDR_COUNT:  bus.DOut[CNT_W-1:0] = count_reg;
      default:     bus.DOut            = '0;
    endcase
  end

  assign IRQ = im & (irq_flag_reg | ((state_reg == INT) && (mode == 2'b01)));

endmodule

// File: tb/tb_timer_counter.sv
// Directed testbench for timer_counter: stimulus pushes expected DOut/IRQ into a queue,
// a negedge monitor pops one entry per cycle and compares against the DUT.
module tb_timer_counter;

  localparam logic [1:0] A_CTRL = 2'b00, A_PRE = 2'b01, A_CNT = 2'b10, A_NONE = 2'b11;

  logic clk;
  logic reset;
  logic IRQ;

  timer_counter_if bus();

  timer_counter #(.CNT_W(32)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .IRQ   (IRQ)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       nm;
    bit          dv;
    logic [31:0] d;
    int          irq;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic void check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h required %h", nm, act, req);
    end
  endfunction

  // Monitor: the design has no valid strobe, so one expected entry is consumed per cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      if (e.dv) check({e.nm, ".dout"}, bus.DOut, e.d);
      if (e.irq >= 0) check({e.nm, ".irq"}, {31'b0, IRQ}, e.irq[31:0]);
      $display("[TB] %s addr=%0d dout=%h irq=%0b", e.nm, bus.Addr, bus.DOut, IRQ);
    end
  end

  // Called at posedge+1; the negedge monitor sees the state left by the previous edge.
  task automatic cyc(input logic we, input logic [1:0] a, input logic [31:0] d,
                     input bit dv, input logic [31:0] ed, input int ei, input string nm);
    exp_t e;
    bus.WE   = we;
    bus.Addr = a;
    bus.DIn  = d;
    if (dv || ei >= 0) begin
      e.nm = nm; e.dv = dv; e.d = ed; e.irq = ei;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.WE = 1'b0;
  endtask

  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    cyc(1'b1, a, d, 1'b0, 32'h0, -1, "");
  endtask

  task automatic rd(input logic [1:0] a, input logic [31:0] ed, input int ei, input string nm);
    cyc(1'b0, a, 32'h0, 1'b1, ed, ei, nm);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int os_cnt[8];
    int per_pat[5];
    int chg_cnt[9];
    int chg_irq[9];
    logic [1:0] a;

    os_cnt  = '{0, 0, 5, 4, 3, 2, 1, 0};
    per_pat = '{3, 2, 1, 0, 0};
    chg_cnt = '{2, 1, 0, 0, 1, 0, 0, 1, 0};
    chg_irq = '{0, 0, 1, 0, 0, 1, 0, 0, 1};

    reset    = 1'b0;
    bus.WE   = 1'b0;
    bus.Addr = A_CTRL;
    bus.DIn  = 32'h0;
    @(posedge clk);
    #1;

    // Reset held with writes toggling: everything reads zero.
    for (int k = 0; k < 8; k++) begin
      a = k[1:0];
      cyc(k[0], a, 32'hDEADBEEF, 1'b1, 32'h0, 0, "reset_dout");
    end
    reset = 1'b1;
    for (int k = 0; k < 3; k++) rd(A_CNT, 32'h0, 0, "idle_count");
    rd(A_CTRL, 32'h0, 0, "idle_ctrl");

    // One-shot, PRESET=5. Same-cycle write/read of PRESET returns old value.
    cyc(1'b1, A_PRE, 32'd5, 1'b1, 32'h0, 0, "preset_old_on_write");
    wr(A_CTRL, 32'h9);
    for (int k = 0; k < 8; k++) rd(A_CNT, os_cnt[k], 0, "oneshot_count");
    rd(A_CTRL, 32'h8, 1, "oneshot_ctrl_irq");
    rd(A_CNT, 32'h0, 1, "oneshot_irq_sticky");
    cyc(1'b1, A_PRE, 32'd7, 1'b1, 32'd5, 1, "preset_write_irq_old");
    rd(A_PRE, 32'd7, 0, "preset_write_clears_irq");

    // Periodic, PRESET=3: IRQ pulses every 5 cycles.
    wr(A_PRE, 32'd3);
    wr(A_CTRL, 32'hB);
    for (int k = 1; k <= 22; k++) begin
      if (k < 3) rd(A_CNT, 32'h0, 0, "periodic_count");
      else rd(A_CNT, per_pat[(k - 3) % 5], ((k - 3) % 5 == 3) ? 1 : 0, "periodic_count");
    end
    // PRESET changed to 1 mid-count: period becomes 3 after the next reload.
    cyc(1'b1, A_PRE, 32'd1, 1'b1, 32'd3, 0, "periodic_preset_change");
    for (int k = 0; k < 9; k++) rd(A_CNT, chg_cnt[k], chg_irq[k], "periodic_new_period");
    wr(A_CTRL, 32'h0);
    cyc(1'b0, A_CNT, 32'h0, 1'b0, 32'h0, -1, "");

    // Masked one-shot: expires silently, then an IM write clears the flag.
    wr(A_PRE, 32'd2);
    wr(A_CTRL, 32'h1);
    for (int k = 1; k <= 5; k++) rd(A_CTRL, 32'h1, 0, "masked_ctrl_running");
    rd(A_CTRL, 32'h0, 0, "masked_enable_cleared");
    rd(A_CTRL, 32'h0, 0, "masked_irq_low");
    cyc(1'b1, A_CTRL, 32'h8, 1'b1, 32'h0, 0, "im_write");
    rd(A_CTRL, 32'h8, 0, "im_write_cleared_flag");
    rd(A_CNT, 32'h0, 0, "im_write_irq_low");

    // Pause: disable lands as COUNT reaches 7, then COUNT holds.
    wr(A_PRE, 32'd20);
    wr(A_CTRL, 32'h1);
    for (int k = 1; k <= 14; k++) rd(A_CNT, (k < 3) ? 32'd0 : 32'(23 - k), 0, "pause_count");
    cyc(1'b1, A_CTRL, 32'h0, 1'b1, 32'h1, 0, "pause_write");
    for (int k = 0; k < 10; k++) rd(A_CNT, 32'd7, 0, "pause_hold");

    // Re-enable reloads from PRESET rather than resuming.
    wr(A_CTRL, 32'h1);
    rd(A_CNT, 32'd7, 0, "reenable_idle");
    rd(A_CNT, 32'd7, 0, "reenable_load");
    rd(A_CNT, 32'd20, 0, "reenable_reload");
    wr(A_CTRL, 32'h0);

    // PRESET=0 one-shot.
    wr(A_PRE, 32'h0);
    wr(A_CTRL, 32'h9);
    rd(A_CNT, 32'd18, 0, "p0_idle");
    rd(A_CNT, 32'd18, 0, "p0_load");
    rd(A_CNT, 32'd0, 0, "p0_cnt");
    cyc(1'b0, A_CNT, 32'h0, 1'b1, 32'h0, -1, "p0_int");
    rd(A_CNT, 32'd0, 1, "p0_irq");
    rd(A_CTRL, 32'h8, 1, "p0_ctrl");

    // Max PRESET: first decrement gives 0xFFFFFFFE.
    wr(A_PRE, 32'hFFFFFFFF);
    wr(A_CTRL, 32'h1);
    rd(A_CNT, 32'h0, 0, "max_idle");
    rd(A_CNT, 32'h0, 0, "max_load");
    rd(A_CNT, 32'hFFFFFFFF, 0, "max_loaded");
    rd(A_CNT, 32'hFFFFFFFE, 0, "max_decrement");
    wr(A_CTRL, 32'h0);

    // Unused address: write ignored, reads zero.
    cyc(1'b1, A_NONE, 32'hDEADBEEF, 1'b1, 32'h0, 0, "addr3_write");
    rd(A_CTRL, 32'h0, 0, "addr3_ctrl");
    rd(A_PRE, 32'hFFFFFFFF, 0, "addr3_preset");
    rd(A_CNT, 32'hFFFFFFFC, 0, "addr3_count");
    rd(A_NONE, 32'h0, 0, "addr3_read");

    // Async reset in periodic mode at COUNT=100, checked before any clock edge.
    wr(A_PRE, 32'd200);
    wr(A_CTRL, 32'hB);
    for (int k = 1; k <= 102; k++) cyc(1'b0, A_CNT, 32'h0, 1'b0, 32'h0, -1, "");
    bus.Addr = A_CNT;
    #1;
    check("async_pre_count", bus.DOut, 32'd100);
    reset = 1'b0;
    #1;
    check("async_irq", {31'b0, IRQ}, 32'h0);
    for (int k = 0; k < 4; k++) begin
      bus.Addr = k[1:0];
      #1;
      check("async_dout", bus.DOut, 32'h0);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    rd(A_CNT, 32'h0, 0, "post_reset_count");
    rd(A_CTRL, 32'h0, 0, "post_reset_ctrl");
    rd(A_PRE, 32'h0, 0, "post_reset_preset");
    for (int k = 0; k < 3; k++) cyc(1'b0, A_CNT, 32'h0, 1'b0, 32'h0, -1, "");
    rd(A_CNT, 32'h0, 0, "post_reset_stays_idle");

    @(posedge clk);
    #1;
    if (exp_q.size() != 0) check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
